// File: rtl/qk_inst_sequencer.sv
// rtl/qk_inst_sequencer.sv - fullchip instruction stream sequencer for one attention pass
module qk_inst_sequencer #(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int pr          = 16,
  parameter int bw          = 8,
  parameter int addr_bw     = 4,
  parameter int idle_gap    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   skip_kload,
  input  logic [pr*bw-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [pr*bw-1:0]       mem_in,
  output logic [2*addr_bw+8:0]   inst,
  output logic                   acc,
  output logic                   div,
  output logic                   wr_norm,
  output logic                   fifo_ext_rd,
  output logic                   busy,
  output logic                   done
);

  // Phase counter is wide enough for the longest phase (NORM = 2*total_cycle).
  localparam int CW = 16;
  localparam logic [CW-1:0] TC_LAST   = CW'(total_cycle - 1);
  localparam logic [CW-1:0] TC_FULL   = CW'(total_cycle);
  localparam logic [CW-1:0] COL_LAST  = CW'(col - 1);
  localparam logic [CW-1:0] COL_FULL  = CW'(col);
  localparam logic [CW-1:0] LOAD_LAST = CW'(col + 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(idle_gap - 1);
  localparam logic [CW-1:0] NORM_LAST = CW'(2 * total_cycle - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_GAP_K, S_LOAD, S_GAP_E,
    S_EXEC, S_GAP_O, S_OFRD, S_NACC, S_NORM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                skip_q, skip_d;
  logic [pr*bw-1:0]    mem_in_q, mem_in_d;
  logic [addr_bw-1:0]  qk_add_q, qk_add_d;
  logic [addr_bw-1:0]  pmem_add_q, pmem_add_d;
  logic                ofifo_rd_q, ofifo_rd_d;
  logic                execute_q, execute_d;
  logic                load_q, load_d;
  logic                qmem_rd_q, qmem_rd_d;
  logic                qmem_wr_q, qmem_wr_d;
  logic                kmem_rd_q, kmem_rd_d;
  logic                kmem_wr_q, kmem_wr_d;
  logic                pmem_rd_q, pmem_rd_d;
  logic                pmem_wr_q, pmem_wr_d;
  logic                acc_q, acc_d;
  logic                div_q, div_d;
  logic                wr_norm_q, wr_norm_d;
  logic                fifo_ext_rd_q, fifo_ext_rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                beat;

  assign in_ready = (state_q == S_QWR) || (state_q == S_KWR);
  assign beat     = in_ready && in_valid;

  // Phase sequencing: each state runs for a fixed cycle count, host phases advance per beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          skip_d  = skip_kload;
          state_d = S_QWR;
          cnt_d   = '0;
        end
      end
      S_QWR: begin
        if (beat) begin
          if (cnt_q == TC_LAST) begin
            state_d = skip_q ? S_GAP_E : S_KWR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_KWR: begin
        if (beat) begin
          if (cnt_q == COL_LAST) begin
            state_d = S_GAP_K;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_GAP_K: begin
        if (cnt_q == ONE) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_GAP_E;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_GAP_E: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_EXEC: begin
        if (cnt_q == TC_LAST) begin
          state_d = S_GAP_O;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_GAP_O: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_OFRD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_OFRD: begin
        if (cnt_q == TC_LAST) begin
          state_d = S_NACC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_NACC: begin
        if (cnt_q == TC_FULL) begin
          state_d = S_NORM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_NORM: begin
        if (cnt_q == NORM_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so controls line up with their phase;
  // host writes are overlaid one cycle after the accepting edge.
  always_comb begin
    mem_in_d      = mem_in_q;
    qk_add_d      = '0;
    pmem_add_d    = '0;
    ofifo_rd_d    = 1'b0;
    execute_d     = 1'b0;
    load_d        = 1'b0;
    qmem_rd_d     = 1'b0;
    qmem_wr_d     = 1'b0;
    kmem_rd_d     = 1'b0;
    kmem_wr_d     = 1'b0;
    pmem_rd_d     = 1'b0;
    pmem_wr_d     = 1'b0;
    acc_d         = 1'b0;
    div_d         = 1'b0;
    wr_norm_d     = 1'b0;
    fifo_ext_rd_d = 1'b0;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    case (state_d)
      S_LOAD: begin
        load_d = 1'b1;
        if ((cnt_d >= ONE) && (cnt_d <= COL_FULL)) begin
          kmem_rd_d = 1'b1;
          qk_add_d  = addr_bw'(cnt_d - ONE);
        end
      end
      S_EXEC: begin
        execute_d = 1'b1;
        qmem_rd_d = 1'b1;
        qk_add_d  = addr_bw'(cnt_d);
      end
      S_OFRD: begin
        ofifo_rd_d = 1'b1;
        pmem_wr_d  = 1'b1;
        pmem_add_d = addr_bw'(cnt_d);
      end
      S_NACC: begin
        pmem_rd_d = 1'b1;
        if (cnt_d != '0) begin
          acc_d      = 1'b1;
          pmem_add_d = addr_bw'(cnt_d - ONE);
        end
      end
      S_NORM: begin
        // Even cycles read and divide row r, odd cycles write it back in place.
        pmem_add_d = addr_bw'(cnt_d >> 1);
        if (cnt_d[0] == 1'b0) begin
          pmem_rd_d     = 1'b1;
          div_d         = 1'b1;
          fifo_ext_rd_d = 1'b1;
        end else begin
          pmem_wr_d = 1'b1;
          wr_norm_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (in_ready) begin
      if (beat) begin
        mem_in_d = in_data;
        qk_add_d = addr_bw'(cnt_q);
        if (state_q == S_QWR) begin
          qmem_wr_d = 1'b1;
        end else begin
          kmem_wr_d = 1'b1;
        end
      end else begin
        qk_add_d = qk_add_q;
      end
    end
  end

  // State and registered outputs; reset clears everything including an in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      skip_q        <= 1'b0;
      mem_in_q      <= '0;
      qk_add_q      <= '0;
      pmem_add_q    <= '0;
      ofifo_rd_q    <= 1'b0;
      execute_q     <= 1'b0;
      load_q        <= 1'b0;
      qmem_rd_q     <= 1'b0;
      qmem_wr_q     <= 1'b0;
      kmem_rd_q     <= 1'b0;
      kmem_wr_q     <= 1'b0;
      pmem_rd_q     <= 1'b0;
      pmem_wr_q     <= 1'b0;
      acc_q         <= 1'b0;
      div_q         <= 1'b0;
      wr_norm_q     <= 1'b0;
      fifo_ext_rd_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      skip_q        <= skip_d;
      mem_in_q      <= mem_in_d;
      qk_add_q      <= qk_add_d;
      pmem_add_q    <= pmem_add_d;
      ofifo_rd_q    <= ofifo_rd_d;
      execute_q     <= execute_d;
      load_q        <= load_d;
      qmem_rd_q     <= qmem_rd_d;
      qmem_wr_q     <= qmem_wr_d;
      kmem_rd_q     <= kmem_rd_d;
      kmem_wr_q     <= kmem_wr_d;
      pmem_rd_q     <= pmem_rd_d;
      pmem_wr_q     <= pmem_wr_d;
      acc_q         <= acc_d;
      div_q         <= div_d;
      wr_norm_q     <= wr_norm_d;
      fifo_ext_rd_q <= fifo_ext_rd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_in      = mem_in_q;
  assign inst        = {ofifo_rd_q, qk_add_q, pmem_add_q, execute_q, load_q, qmem_rd_q,
                        qmem_wr_q, kmem_rd_q, kmem_wr_q, pmem_rd_q, pmem_wr_q};
  assign acc         = acc_q;
  assign div         = div_q;
  assign wr_norm     = wr_norm_q;
  assign fifo_ext_rd = fifo_ext_rd_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
